// File: rtl/multicycle_ctrl_if.sv
// Purpose: bundles the control unit's handshake, instruction and datapath-control signals.
// Latency: none, wires only.
// Backpressure: memory requests are held by the controller until the matching ack arrives.
interface multicycle_ctrl_if #(
    parameter int INSTR_W = 32,
    parameter int ALUOP_W = 4
);
    // Environment -> controller
    logic               start;
    logic [INSTR_W-1:0] instr;
    logic               imem_ack;
    logic               dmem_ack;
    logic               zero;

    // Controller -> memories / datapath
    logic               imem_req;
    logic               mem_read;
    logic               mem_write;
    logic               pc_update;
    logic               reg_dst;
    logic               alu_src;
    logic               mem_to_reg;
    logic               reg_write;
    logic               branch;
    logic               jump;
    logic [ALUOP_W-1:0] alu_op;
    logic               sp_sel;
    logic               sp_inc;
    logic               sp_dec;
    logic               halted;
    logic               illegal;
    logic               timeout;
    logic [3:0]         state;

    // Controller side
    modport master (
        input  start, instr, imem_ack, dmem_ack, zero,
        output imem_req, mem_read, mem_write, pc_update, reg_dst, alu_src,
               mem_to_reg, reg_write, branch, jump, alu_op, sp_sel, sp_inc,
               sp_dec, halted, illegal, timeout, state
    );

    // Memory / datapath side
    modport slave (
        output start, instr, imem_ack, dmem_ack, zero,
        input  imem_req, mem_read, mem_write, pc_update, reg_dst, alu_src,
               mem_to_reg, reg_write, branch, jump, alu_op, sp_sel, sp_inc,
               sp_dec, halted, illegal, timeout, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Purpose: multicycle CPU control FSM (fetch/decode/exec/mem/wb); MULTICYCLE_CTRL_STACK_EN adds PUSH/POP.
// Latency: R/I-ALU 4, LD 5, ST 4, BEQ 3, JMP 2 cycles with single-cycle acks.
// Backpressure: imem_req/mem_read/mem_write held until ack; MEM_TIMEOUT cycles without ack -> ERR.
module multicycle_ctrl #(
    parameter int INSTR_W     = 32,
    parameter int ALUOP_W     = 4,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    multicycle_ctrl_if.master   bus
);
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_MEM    = 4'd4,
        S_WB     = 4'd5,
        S_STK    = 4'd6,
        S_HALT   = 4'd7,
        S_ERR    = 4'd8
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [7:0]         wait_q, wait_d;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       is_r, is_i, is_ld, is_st, is_beq, is_jmp, is_halt, is_push, is_pop, is_ill;
    logic       ir_unused;

    assign opcode    = ir_q[INSTR_W-1 -: 6];
    assign funct     = ir_q[5:0];
    assign ir_unused = ^ir_q;

    assign is_r    = (opcode == 6'b000000);
    assign is_i    = (opcode == 6'b000001);
    assign is_ld   = (opcode == 6'b000010);
    assign is_st   = (opcode == 6'b000011);
    assign is_beq  = (opcode == 6'b000100);
    assign is_jmp  = (opcode == 6'b000101);
    assign is_halt = (opcode == 6'b111111);
`ifdef MULTICYCLE_CTRL_STACK_EN
    assign is_push = (opcode == 6'b000110);
    assign is_pop  = (opcode == 6'b000111);
`else
    assign is_push = 1'b0;
    assign is_pop  = 1'b0;
`endif
    assign is_ill  = !(is_r || is_i || is_ld || is_st || is_beq || is_jmp ||
                       is_halt || is_push || is_pop);

    // State, instruction register and wait counter; reset clears all of them asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            wait_q  <= wait_d;
        end
    end

    // Next state, IR capture and memory wait counting
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            S_IDLE:   if (bus.start) state_d = S_FETCH;
            S_FETCH: begin
                if (bus.imem_ack) begin
                    ir_d    = bus.instr;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_ERR;
                end
            end
            S_DECODE: begin
                if (is_jmp || is_ill) state_d = S_FETCH;
                else if (is_halt)     state_d = S_HALT;
                else                  state_d = S_EXEC;
            end
            S_EXEC: begin
                if (is_r || is_i)                          state_d = S_WB;
                else if (is_ld || is_st || is_push || is_pop) state_d = S_MEM;
                else                                       state_d = S_FETCH;
            end
            S_MEM: begin
                if (bus.dmem_ack) begin
                    if (is_ld || is_pop) state_d = S_WB;
                    else if (is_push)    state_d = S_STK;
                    else                 state_d = S_FETCH;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_ERR;
                end
            end
            S_WB:     state_d = S_FETCH;
            S_STK:    state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            S_ERR:    state_d = S_ERR;
            default:  state_d = S_IDLE;
        endcase

        // Counter restarts on every state change, so entry into FETCH/MEM sees zero.
        if (state_d != state_q)
            wait_d = '0;
        else if ((state_q == S_FETCH && !bus.imem_ack) || (state_q == S_MEM && !bus.dmem_ack))
            wait_d = wait_q + 8'd1;
        else
            wait_d = wait_q;
    end

    // Output decode: Moore from state and IR, except pc_update and branch which follow their inputs
    always_comb begin
        bus.imem_req   = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.pc_update  = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.alu_src    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.reg_write  = 1'b0;
        bus.branch     = 1'b0;
        bus.jump       = 1'b0;
        bus.alu_op     = '0;
        bus.sp_sel     = 1'b0;
        bus.sp_inc     = 1'b0;
        bus.sp_dec     = 1'b0;
        bus.halted     = 1'b0;
        bus.illegal    = 1'b0;
        bus.timeout    = 1'b0;
        bus.state      = state_q;
        case (state_q)
            S_FETCH: begin
                bus.imem_req  = 1'b1;
                bus.pc_update = bus.imem_ack;
            end
            S_DECODE: begin
                bus.jump    = is_jmp;
                bus.illegal = is_ill;
            end
            S_EXEC: begin
                if (is_r) begin
                    bus.alu_op = funct[ALUOP_W-1:0];
                end else if (is_beq) begin
                    bus.alu_op = ALUOP_W'(1);
                    bus.branch = bus.zero;
                end else begin
                    bus.alu_src = 1'b1;
                end
`ifdef MULTICYCLE_CTRL_STACK_EN
                bus.sp_sel = is_push || is_pop;
`endif
            end
            S_MEM: begin
                bus.mem_read  = is_ld || is_pop;
                bus.mem_write = is_st || is_push;
`ifdef MULTICYCLE_CTRL_STACK_EN
                bus.sp_sel    = is_push || is_pop;
`endif
            end
            S_WB: begin
                bus.reg_write  = 1'b1;
                bus.reg_dst    = is_r;
                bus.mem_to_reg = is_ld || is_pop;
`ifdef MULTICYCLE_CTRL_STACK_EN
                bus.sp_inc     = is_pop;
`endif
            end
            S_STK: begin
`ifdef MULTICYCLE_CTRL_STACK_EN
                bus.sp_dec = 1'b1;
`endif
            end
            S_HALT:  bus.halted  = 1'b1;
            S_ERR:   bus.timeout = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    // Output vector bit masks (bits 19:0); state sits in bits 23:20.
    localparam logic [19:0] IREQ  = 20'h80000;
    localparam logic [19:0] MRD   = 20'h40000;
    localparam logic [19:0] MWR   = 20'h20000;
    localparam logic [19:0] PCU   = 20'h10000;
    localparam logic [19:0] RDST  = 20'h08000;
    localparam logic [19:0] ASRC  = 20'h04000;
    localparam logic [19:0] M2R   = 20'h02000;
    localparam logic [19:0] RW    = 20'h01000;
    localparam logic [19:0] BR    = 20'h00800;
    localparam logic [19:0] JMPF  = 20'h00400;
    localparam logic [19:0] AOP1  = 20'h00040;
    localparam logic [19:0] SPSEL = 20'h00020;
    localparam logic [19:0] SPINC = 20'h00010;
    localparam logic [19:0] SPDEC = 20'h00008;
    localparam logic [19:0] HLT   = 20'h00004;
    localparam logic [19:0] ILL   = 20'h00002;
    localparam logic [19:0] TMO   = 20'h00001;

    multicycle_ctrl_if #(.INSTR_W(32), .ALUOP_W(4)) bus ();

    multicycle_ctrl #(.INSTR_W(32), .ALUOP_W(4), .MEM_TIMEOUT(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [23:0] obs;
    assign obs = {bus.state, bus.imem_req, bus.mem_read, bus.mem_write, bus.pc_update,
                  bus.reg_dst, bus.alu_src, bus.mem_to_reg, bus.reg_write, bus.branch,
                  bus.jump, bus.alu_op, bus.sp_sel, bus.sp_inc, bus.sp_dec,
                  bus.halted, bus.illegal, bus.timeout};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] ex(input logic [3:0] st, input logic [19:0] f);
        return {st, f};
    endfunction

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [5:0] fn);
        return {op, 20'h0, fn};
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Inputs already applied; check this cycle's outputs, then advance one clock.
    task automatic step(input string tag, input logic [23:0] e);
        #1;
        check(tag, {8'h0, obs}, {8'h0, e});
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string tag, input logic [31:0] v);
        bus.imem_ack = 1'b1;
        bus.instr    = v;
        step(tag, ex(4'd1, IREQ | PCU));
        bus.imem_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("reset_async", {8'h0, obs}, 32'h0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        bus.start = 1'b1;
        step("restart_idle", ex(4'd0, 20'h0));
        bus.start = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.instr = '0;
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        bus.zero = 1'b0;

        // Reset state, and start ignored while reset is held
        #2;
        check("reset_outputs", {8'h0, obs}, 32'h0);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        #1;
        check("start_in_reset", {8'h0, obs}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.start = 1'b0;
        step("idle_no_start", ex(4'd0, 20'h0));
        bus.start = 1'b1;
        step("idle_start", ex(4'd0, 20'h0));
        bus.start = 1'b0;

        // R-type 0x00221820: FETCH, DECODE, EXEC, WB
        fetch("r_fetch", 32'h0022_1820);
        step("r_decode", ex(4'd2, 20'h0));
        step("r_exec", ex(4'd3, 20'h0));
        step("r_wb", ex(4'd5, RW | RDST));

        // R-type with funct 0x2B -> alu_op 0xB
        fetch("r2_fetch", mk(6'h00, 6'h2B));
        step("r2_decode", ex(4'd2, 20'h0));
        step("r2_exec", ex(4'd3, 20'hB << 6));
        step("r2_wb", ex(4'd5, RW | RDST));

        // I-ALU
        fetch("i_fetch", mk(6'h01, 6'h3F));
        step("i_decode", ex(4'd2, 20'h0));
        step("i_exec", ex(4'd3, ASRC));
        step("i_wb", ex(4'd5, RW));

        // LD with dmem_ack delayed 3 cycles
        fetch("ld_fetch", mk(6'h02, 6'h00));
        step("ld_decode", ex(4'd2, 20'h0));
        step("ld_exec", ex(4'd3, ASRC));
        for (int i = 0; i < 3; i++) step("ld_mem_wait", ex(4'd4, MRD));
        bus.dmem_ack = 1'b1;
        step("ld_mem_ack", ex(4'd4, MRD));
        bus.dmem_ack = 1'b0;
        step("ld_wb", ex(4'd5, RW | M2R));

        // ST with immediate ack
        fetch("st_fetch", mk(6'h03, 6'h00));
        step("st_decode", ex(4'd2, 20'h0));
        step("st_exec", ex(4'd3, ASRC));
        bus.dmem_ack = 1'b1;
        step("st_mem", ex(4'd4, MWR));
        bus.dmem_ack = 1'b0;

        // BEQ taken then not taken
        fetch("beq1_fetch", mk(6'h04, 6'h00));
        step("beq1_decode", ex(4'd2, 20'h0));
        bus.zero = 1'b1;
        step("beq1_exec", ex(4'd3, AOP1 | BR));
        bus.zero = 1'b0;
        fetch("beq0_fetch", mk(6'h04, 6'h00));
        step("beq0_decode", ex(4'd2, 20'h0));
        step("beq0_exec", ex(4'd3, AOP1));

        // JMP
        fetch("jmp_fetch", mk(6'h05, 6'h00));
        step("jmp_decode", ex(4'd2, JMPF));

        // Illegal opcode
        fetch("ill_fetch", mk(6'h0A, 6'h00));
        step("ill_decode", ex(4'd2, ILL));

        // Opcodes 000110 / 000111
        fetch("op6_fetch", mk(6'h06, 6'h00));
`ifdef MULTICYCLE_CTRL_STACK_EN
        step("push_decode", ex(4'd2, 20'h0));
        step("push_exec", ex(4'd3, ASRC | SPSEL));
        bus.dmem_ack = 1'b1;
        step("push_mem", ex(4'd4, MWR | SPSEL));
        bus.dmem_ack = 1'b0;
        step("push_stk", ex(4'd6, SPDEC));
        fetch("op7_fetch", mk(6'h07, 6'h00));
        step("pop_decode", ex(4'd2, 20'h0));
        step("pop_exec", ex(4'd3, ASRC | SPSEL));
        bus.dmem_ack = 1'b1;
        step("pop_mem", ex(4'd4, MRD | SPSEL));
        bus.dmem_ack = 1'b0;
        step("pop_wb", ex(4'd5, RW | M2R | SPINC));
`else
        step("op6_illegal", ex(4'd2, ILL));
        fetch("op7_fetch", mk(6'h07, 6'h00));
        step("op7_illegal", ex(4'd2, ILL));
`endif

        // imem_ack arriving on the 16th waiting cycle wins
        for (int i = 0; i < 15; i++) step("fetch_wait15", ex(4'd1, IREQ));
        fetch("fetch_ack16", mk(6'h05, 6'h00));
        step("after_ack16_decode", ex(4'd2, JMPF));

        // dmem_ack arriving on the 16th waiting cycle wins
        fetch("ld16_fetch", mk(6'h02, 6'h00));
        step("ld16_decode", ex(4'd2, 20'h0));
        step("ld16_exec", ex(4'd3, ASRC));
        for (int i = 0; i < 15; i++) step("ld16_mem_wait", ex(4'd4, MRD));
        bus.dmem_ack = 1'b1;
        step("ld16_mem_ack", ex(4'd4, MRD));
        bus.dmem_ack = 1'b0;
        step("ld16_wb", ex(4'd5, RW | M2R));

        // imem_ack withheld 16 cycles -> ERR, start ignored there
        for (int i = 0; i < 16; i++) step("fetch_wait16", ex(4'd1, IREQ));
        bus.start = 1'b1;
        bus.imem_ack = 1'b1;
        step("err_entry", ex(4'd8, TMO));
        step("err_stays", ex(4'd8, TMO));
        bus.start = 1'b0;
        bus.imem_ack = 1'b0;
        do_reset();

        // dmem ack never arrives for ST -> ERR
        fetch("st_to_fetch", mk(6'h03, 6'h00));
        step("st_to_decode", ex(4'd2, 20'h0));
        step("st_to_exec", ex(4'd3, ASRC));
        for (int i = 0; i < 16; i++) step("st_to_wait", ex(4'd4, MWR));
        step("st_to_err", ex(4'd8, TMO));
        do_reset();

        // Reset in the middle of a pending LD
        fetch("ldr_fetch", mk(6'h02, 6'h00));
        step("ldr_decode", ex(4'd2, 20'h0));
        step("ldr_exec", ex(4'd3, ASRC));
        step("ldr_mem", ex(4'd4, MRD));
        rst_n = 1'b0;
        bus.dmem_ack = 1'b1;
        #1;
        check("mid_mem_reset", {8'h0, obs}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("ack_in_reset_ignored", ex(4'd0, 20'h0));
        bus.dmem_ack = 1'b0;
        step("idle_after_reset", ex(4'd0, 20'h0));
        bus.start = 1'b1;
        step("restart_idle2", ex(4'd0, 20'h0));
        bus.start = 1'b0;

        // HALT is sticky
        fetch("halt_fetch", mk(6'h3F, 6'h00));
        step("halt_decode", ex(4'd2, 20'h0));
        bus.start = 1'b1;
        bus.imem_ack = 1'b1;
        bus.dmem_ack = 1'b1;
        for (int i = 0; i < 4; i++) step("halt_sticky", ex(4'd7, HLT));
        bus.start = 1'b0;
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        rst_n = 1'b0;
        #1;
        check("halt_reset", {8'h0, obs}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
